mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter that shares the single DRAM-side system bus between the instruction cache (port 0) and the data cache (port 1). It grants one whole bus transaction at a time, round-robin between the ports. A transaction is an address beat plus eight 64-bit data beats, either write data or read response. While a transaction is open, all handshakes pass through combinationally between the owner and memory. It sits between the two cache `m_bus_*` interfaces and the memory model.

## Interface
- `BUS_DATA_WIDTH`, default 64: data/address beat width.
- `BUS_TAG_WIDTH`, default 13: tag width; bit 12 is the read/write flag and is compared against `` `SYSBUS_WRITE ``.
- `BEATS`, default 8: data beats per transaction (512-bit line).
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `c0_reqcyc`, `c1_reqcyc`  in  1  requester has a beat on the request channel.
- `c0_reqack`, `c1_reqack`  out  1  request beat accepted.
- `c0_req`, `c1_req`  in  BUS_DATA_WIDTH  address beat or write data beat.
- `c0_reqtag`, `c1_reqtag`  in  BUS_TAG_WIDTH  request tag.
- `c0_respcyc`, `c1_respcyc`  out  1  response beat valid.
- `c0_respack`, `c1_respack`  in  1  response beat taken.
- `c0_resp`, `c1_resp`  out  BUS_DATA_WIDTH  response data.
- `c0_resptag`, `c1_resptag`  out  BUS_TAG_WIDTH  response tag.
- `m_bus_reqcyc`  out  1; `m_bus_reqack`  in  1; `m_bus_req`  out  BUS_DATA_WIDTH; `m_bus_reqtag`  out  BUS_TAG_WIDTH: memory request channel.
- `m_bus_respcyc`  in  1; `m_bus_respack`  out  1; `m_bus_resp`  in  BUS_DATA_WIDTH; `m_bus_resptag`  in  BUS_TAG_WIDTH: memory response channel.
- `owner`  out  2  debug: `{busy, granted_port}`.

## Operation
- **State machine:** IDLE, ADDR, WDATA, RDATA, plus SNOOP (only when the configuration macro is defined).
- **IDLE**
  - No output is driven active.
  - If any `cN_reqcyc` is high, select a port: a lone requester wins; if both request, the port not granted last wins.
  - Latch the winner in `gnt` and its tag bit 12 in `is_wr`; go to ADDR.
  - `last` updates to the winner on this transition.
- **ADDR**
  - Pass through: `m_bus_reqcyc`/`m_bus_req`/`m_bus_reqtag` = owner's request signals; owner's `reqack` = `m_bus_reqack`.
  - On `m_bus_reqack`: clear `beat`; go to WDATA if `is_wr`, else RDATA.
- **WDATA**
  - Same request pass-through; `m_bus_reqtag` holds the latched address-beat tag.
  - Each cycle with `m_bus_reqack`: `beat++`. On the ack of beat BEATS-1, go to IDLE.
- **RDATA**
  - Owner's `respcyc`/`resp`/`resptag` = memory's; `m_bus_respack` = owner's `respack`.
  - Each beat completes when `m_bus_respcyc & m_bus_respack`; `beat++`. On the completion of beat BEATS-1, go to IDLE.
- **Non-owner port:** `reqack` = 0 and `respcyc` = 0 at all times. Its `reqcyc` may stay high indefinitely and must be held until it is granted.
- **`beat`:** 3 bits for BEATS = 8; it wraps 7→0 exactly at transaction end.
- **Reset mid-transaction:** all state is dropped. The memory side must be reset together with the arbiter; no recovery of a partial transaction.

## Timing
- Reset values: all `cN_reqack`, `cN_respcyc`, `m_bus_reqcyc`, `m_bus_respack` = 0; data/tag outputs = 0; state = IDLE; `gnt` = 0; `last` = 1, so port 0 wins the first tie; `owner` = 2'b00.
- Grant latency: request seen in IDLE at cycle N → `m_bus_reqcyc` high in cycle N+1.
- Inside a transaction every handshake is combinational (zero added latency); the arbiter never inserts a bubble between beats.
- Back-to-back: after the final beat the arbiter returns to IDLE for one cycle, so the minimum gap between transactions is 1 cycle.
- Both ports requesting continuously alternate 0,1,0,1.
- A request that rises in the same cycle a transaction ends is seen in the following IDLE cycle.

## Configuration
- `ARB_SNOOP_FWD_EN` defined:
  - In IDLE, `m_bus_respcyc` with `m_bus_resptag == INVAL_TAG` (13'h800) enters SNOOP; this takes priority over pending requests.
  - SNOOP drives `respcyc`/`resp`/`resptag` to both ports.
  - `m_bus_respack` = `c0_respack & c1_respack` sampled over the hold; leave SNOOP once both have acked, each port's ack being remembered in a 2-bit register.
- `ARB_SNOOP_FWD_EN` undefined: SNOOP does not exist; an unsolicited response in IDLE is not acked and is ignored.

## Structure
- Package `sysbus_arb_pkg`:
  - state enum `arb_state_t`;
  - constants `BEATS`, `INVAL_TAG`, `TAG_WR_BIT = 12`.
- Sub-module `mem_arb_rr2`: combinational 2-way round-robin picker. Inputs: `req[1:0]`, `last`. Outputs: `valid`, `winner`.

## Test plan
- Port 0 read of 0x1000 alone → `m_bus_req` = 0x1000 one cycle later; 8 response beats 0xA0..0xA7 appear on `c0_resp` only; `c1_respcyc` stays 0; return to IDLE.
- Both ports request in the same cycle out of reset → port 0 granted first, then port 1; with both held high the grant order is 0,1,0,1 over 4 transactions.
- Port 1 write to 0x2040 (tag bit 12 = `` `SYSBUS_WRITE ``) with data 0xD0..0xD7 and memory acking every other cycle → 9 request beats forwarded in order; no response routed; IDLE after the 8th data ack.
- `reset` driven low during beat 4 of a port 0 read → all outputs 0 immediately; after release, port 0 wins the first tie again.
- `ARB_SNOOP_FWD_EN`: tag 13'h800 with address 0x3000 in IDLE while port 1 requests → both ports see `respcyc`; `m_bus_respack` held until both ack; port 1 then granted.
- Response beat with `c0_respack` held low for 5 cycles → `m_bus_respack` stays 0 and `beat` does not advance.

Source files
------------

// File: rtl/sysbus_arb_pkg.sv
// rtl/sysbus_arb_pkg.sv - shared state type and bus constants for the system bus arbiter
// Snoop state exists only when ARB_SNOOP_FWD_EN is defined.
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b1
`endif

package sysbus_arb_pkg;

  localparam int          BEATS      = 8;
  localparam logic [12:0] INVAL_TAG  = 13'h800;
  localparam int          TAG_WR_BIT = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
`ifdef ARB_SNOOP_FWD_EN
    ST_RDATA,
    ST_SNOOP
`else
    ST_RDATA
`endif
  } arb_state_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// rtl/mem_arb_rr2.sv - combinational two-way round-robin picker
// On a tie the port that did not win last time is chosen.
module mem_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin owner of the DRAM system bus for I-cache (port 0) and D-cache (port 1)
// Optional broadcast of invalidation responses to both ports: ARB_SNOOP_FWD_EN.
module mem_bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      c0_reqcyc,
  output logic                      c0_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] c0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
  output logic                      c0_respcyc,
  input  logic                      c0_respack,
  output logic [BUS_DATA_WIDTH-1:0] c0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,

  input  logic                      c1_reqcyc,
  output logic                      c1_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] c1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
  output logic                      c1_respcyc,
  input  logic                      c1_respack,
  output logic [BUS_DATA_WIDTH-1:0] c1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,

  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,

  output logic [1:0]                owner
);

  import sysbus_arb_pkg::*;

  localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  arb_state_t               state;
  logic                     gnt;
  logic                     last;
  logic                     is_wr;
  logic [BEAT_W-1:0]        beat;
  logic [BUS_TAG_WIDTH-1:0] tag_q;

  logic                      pick_valid;
  logic                      pick_winner;
  logic [BUS_TAG_WIDTH-1:0]  win_tag;
  logic                      own_reqcyc;
  logic                      own_respack;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;

`ifdef ARB_SNOOP_FWD_EN
  logic [1:0] snoop_ack;
  logic       snoop_done;
  logic       snoop_hit;

  assign snoop_done = (snoop_ack[0] | c0_respack) & (snoop_ack[1] | c1_respack);
  assign snoop_hit  = m_bus_respcyc && (m_bus_resptag == BUS_TAG_WIDTH'(INVAL_TAG));
`endif

  mem_arb_rr2 u_pick (
    .req    ({c1_reqcyc, c0_reqcyc}),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign win_tag     = pick_winner ? c1_reqtag  : c0_reqtag;
  assign own_reqcyc  = gnt ? c1_reqcyc  : c0_reqcyc;
  assign own_req     = gnt ? c1_req     : c0_req;
  assign own_reqtag  = gnt ? c1_reqtag  : c0_reqtag;
  assign own_respack = gnt ? c1_respack : c0_respack;
  assign owner       = {state != ST_IDLE, gnt};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      is_wr <= 1'b0;
      beat  <= '0;
      tag_q <= '0;
`ifdef ARB_SNOOP_FWD_EN
      snoop_ack <= 2'b00;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef ARB_SNOOP_FWD_EN
          if (snoop_hit) begin
            snoop_ack <= 2'b00;
            state     <= ST_SNOOP;
          end else
`endif
          if (pick_valid) begin
            gnt   <= pick_winner;
            last  <= pick_winner;
            is_wr <= (win_tag[TAG_WR_BIT] == `SYSBUS_WRITE);
            tag_q <= win_tag;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_bus_reqack) begin
            beat  <= '0;
            state <= is_wr ? ST_WDATA : ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (m_bus_reqack) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) state <= ST_IDLE;
          end
        end
        ST_RDATA: begin
          if (m_bus_respcyc && own_respack) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) state <= ST_IDLE;
          end
        end
`ifdef ARB_SNOOP_FWD_EN
        ST_SNOOP: begin
          snoop_ack <= snoop_ack | {c1_respack, c0_respack};
          if (snoop_done) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Everything below is pure routing; the owner talks straight to memory.
  always_comb begin
    c0_reqack     = 1'b0;
    c1_reqack     = 1'b0;
    c0_respcyc    = 1'b0;
    c1_respcyc    = 1'b0;
    c0_resp       = '0;
    c1_resp       = '0;
    c0_resptag    = '0;
    c1_resptag    = '0;
    m_bus_reqcyc  = 1'b0;
    m_bus_req     = '0;
    m_bus_reqtag  = '0;
    m_bus_respack = 1'b0;
    case (state)
      ST_ADDR, ST_WDATA: begin
        m_bus_reqcyc = own_reqcyc;
        m_bus_req    = own_req;
        m_bus_reqtag = (state == ST_ADDR) ? own_reqtag : tag_q;
        if (gnt) c1_reqack = m_bus_reqack;
        else     c0_reqack = m_bus_reqack;
      end
      ST_RDATA: begin
        m_bus_respack = own_respack;
        if (gnt) begin
          c1_respcyc = m_bus_respcyc;
          c1_resp    = m_bus_resp;
          c1_resptag = m_bus_resptag;
        end else begin
          c0_respcyc = m_bus_respcyc;
          c0_resp    = m_bus_resp;
          c0_resptag = m_bus_resptag;
        end
      end
`ifdef ARB_SNOOP_FWD_EN
      ST_SNOOP: begin
        c0_respcyc    = m_bus_respcyc;
        c1_respcyc    = m_bus_respcyc;
        c0_resp       = m_bus_resp;
        c1_resp       = m_bus_resp;
        c0_resptag    = m_bus_resptag;
        c1_resptag    = m_bus_resptag;
        m_bus_respack = snoop_done;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_reqcyc, c0_reqack, c0_respcyc, c0_respack;
  logic [DW-1:0] c0_req, c0_resp;
  logic [TW-1:0] c0_reqtag, c0_resptag;
  logic          c1_reqcyc, c1_reqack, c1_respcyc, c1_respack;
  logic [DW-1:0] c1_req, c1_resp;
  logic [TW-1:0] c1_reqtag, c1_resptag;
  logic          m_bus_reqcyc, m_bus_reqack, m_bus_respcyc, m_bus_respack;
  logic [DW-1:0] m_bus_req, m_bus_resp;
  logic [TW-1:0] m_bus_reqtag, m_bus_resptag;
  logic [1:0]    owner;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(8)) dut (
    .clk(clk), .reset(reset),
    .c0_reqcyc(c0_reqcyc), .c0_reqack(c0_reqack), .c0_req(c0_req), .c0_reqtag(c0_reqtag),
    .c0_respcyc(c0_respcyc), .c0_respack(c0_respack), .c0_resp(c0_resp), .c0_resptag(c0_resptag),
    .c1_reqcyc(c1_reqcyc), .c1_reqack(c1_reqack), .c1_req(c1_req), .c1_reqtag(c1_reqtag),
    .c1_respcyc(c1_respcyc), .c1_respack(c1_respack), .c1_resp(c1_resp), .c1_resptag(c1_resptag),
    .m_bus_reqcyc(m_bus_reqcyc), .m_bus_reqack(m_bus_reqack), .m_bus_req(m_bus_req),
    .m_bus_reqtag(m_bus_reqtag), .m_bus_respcyc(m_bus_respcyc), .m_bus_respack(m_bus_respack),
    .m_bus_resp(m_bus_resp), .m_bus_resptag(m_bus_resptag),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    c0_reqcyc = 0; c0_req = '0; c0_reqtag = '0; c0_respack = 0;
    c1_reqcyc = 0; c1_req = '0; c1_reqtag = '0; c1_respack = 0;
    m_bus_reqack = 0; m_bus_respcyc = 0; m_bus_resp = '0; m_bus_resptag = '0;
  endtask

  task automatic test_reset;
    reset = 0;
    clear_inputs();
    c0_reqcyc = 1; m_bus_reqack = 1; m_bus_respcyc = 1; m_bus_resp = 64'hFF;
    tick();
    n_checks++;
    if ({m_bus_reqcyc, m_bus_respack, c0_reqack, c1_reqack, c0_respcyc, c1_respcyc} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {m_bus_reqcyc, m_bus_respack, c0_reqack, c1_reqack, c0_respcyc, c1_respcyc});
    end
    n_checks++;
    if ({m_bus_req, m_bus_reqtag, c0_resp, c1_resp} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: req=%h tag=%h c0_resp=%h c1_resp=%h want all 0",
               m_bus_req, m_bus_reqtag, c0_resp, c1_resp);
    end
    n_checks++;
    if (owner !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_owner: got %b want 00", owner);
    end
    clear_inputs();
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_tie_alternate;
    logic exp;
    c0_reqcyc = 1; c0_req = 64'h100;
    c1_reqcyc = 1; c1_req = 64'h200;
    c0_respack = 1; c1_respack = 1;
    for (int k = 0; k < 4; k++) begin
      exp = k[0];
      n_checks++;
      if (owner[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL tie_gap_idle[%0d]: owner=%b want busy=0", k, owner);
      end
      tick();
      n_checks++;
      if (owner !== {1'b1, exp} || m_bus_req !== (exp ? 64'h200 : 64'h100)) begin
        n_fail++;
        $display("FAIL tie_grant[%0d]: owner=%b req=%h want owner=%b req=%h", k, owner, m_bus_req,
                 {1'b1, exp}, exp ? 64'h200 : 64'h100);
      end
      m_bus_reqack = 1;
      tick();
      m_bus_reqack = 0;
      for (int i = 0; i < 8; i++) begin
        m_bus_respcyc = 1; m_bus_resp = 64'(i);
        #1;
        n_checks++;
        if ({c1_respcyc, c0_respcyc} !== (exp ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL tie_resp_route[%0d.%0d]: got %b want %b", k, i,
                   {c1_respcyc, c0_respcyc}, exp ? 2'b10 : 2'b01);
        end
        tick();
      end
      m_bus_respcyc = 0;
      #1;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_read_p0;
    c0_reqcyc = 1; c0_req = 64'h1000; c0_reqtag = 13'h0000;
    #1;
    n_checks++;
    if (m_bus_reqcyc !== 1'b0) begin
      n_fail++;
      $display("FAIL read_latency_idle: m_bus_reqcyc=%b want 0", m_bus_reqcyc);
    end
    tick();
    n_checks++;
    if (m_bus_reqcyc !== 1'b1 || m_bus_req !== 64'h1000) begin
      n_fail++;
      $display("FAIL read_addr: reqcyc=%b req=%h want 1 1000", m_bus_reqcyc, m_bus_req);
    end
    m_bus_reqack = 1;
    #1;
    n_checks++;
    if ({c1_reqack, c0_reqack} !== 2'b01) begin
      n_fail++;
      $display("FAIL read_addr_ack: got %b want 01", {c1_reqack, c0_reqack});
    end
    tick();
    m_bus_reqack = 0; c0_reqcyc = 0; c0_respack = 1;
    for (int i = 0; i < 8; i++) begin
      m_bus_respcyc = 1; m_bus_resp = 64'hA0 + 64'(i); m_bus_resptag = 13'h0005;
      #1;
      n_checks++;
      if (c0_respcyc !== 1'b1 || c1_respcyc !== 1'b0 || c0_resp !== 64'hA0 + 64'(i) ||
          c0_resptag !== 13'h0005 || m_bus_respack !== 1'b1 || owner !== 2'b10) begin
        n_fail++;
        $display("FAIL read_beat[%0d]: c0cyc=%b c1cyc=%b resp=%h tag=%h ack=%b own=%b want 1 0 %h 0005 1 10",
                 i, c0_respcyc, c1_respcyc, c0_resp, c0_resptag, m_bus_respack, owner, 64'hA0 + 64'(i));
      end
      tick();
    end
    m_bus_respcyc = 0;
    #1;
    n_checks++;
    if (owner[1] !== 1'b0 || c0_respcyc !== 1'b0) begin
      n_fail++;
      $display("FAIL read_end_idle: owner=%b c0_respcyc=%b want busy=0 0", owner, c0_respcyc);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_p1;
    logic [DW-1:0] data;
    c1_reqcyc = 1; c1_req = 64'h2040; c1_reqtag = 13'h1000;
    tick();
    for (int b = 0; b < 9; b++) begin
      data = (b == 0) ? 64'h2040 : 64'hD0 + 64'(b - 1);
      c1_req = data;
      c1_reqtag = (b == 0) ? 13'h1000 : 13'h0000;
      m_bus_reqack = 0; m_bus_respcyc = 1; c1_respack = 1;
      #1;
      n_checks++;
      if (m_bus_reqcyc !== 1'b1 || m_bus_req !== data || c1_reqack !== 1'b0 ||
          c1_respcyc !== 1'b0 || m_bus_respack !== 1'b0 || owner !== 2'b11) begin
        n_fail++;
        $display("FAIL write_wait[%0d]: cyc=%b req=%h ack=%b rcyc=%b rack=%b own=%b want 1 %h 0 0 0 11",
                 b, m_bus_reqcyc, m_bus_req, c1_reqack, c1_respcyc, m_bus_respack, owner, data);
      end
      tick();
      m_bus_reqack = 1;
      #1;
      n_checks++;
      if (c1_reqack !== 1'b1 || c0_reqack !== 1'b0 || m_bus_reqtag !== 13'h1000 || m_bus_req !== data) begin
        n_fail++;
        $display("FAIL write_ack[%0d]: c1ack=%b c0ack=%b tag=%h req=%h want 1 0 1000 %h",
                 b, c1_reqack, c0_reqack, m_bus_reqtag, m_bus_req, data);
      end
      tick();
    end
    clear_inputs();
    #1;
    n_checks++;
    if (owner[1] !== 1'b0 || m_bus_reqcyc !== 1'b0) begin
      n_fail++;
      $display("FAIL write_end_idle: owner=%b reqcyc=%b want busy=0 0", owner, m_bus_reqcyc);
    end
    tick();
  endtask

  task automatic test_resp_stall;
    c0_reqcyc = 1; c0_req = 64'h1100; c0_reqtag = 13'h0000;
    tick();
    m_bus_reqack = 1;
    tick();
    m_bus_reqack = 0; c0_reqcyc = 0;
    for (int i = 0; i < 8; i++) begin
      m_bus_respcyc = 1; m_bus_resp = 64'hB0 + 64'(i);
      if (i == 2) begin
        c0_respack = 0;
        for (int s = 0; s < 5; s++) begin
          #1;
          n_checks++;
          if (m_bus_respack !== 1'b0 || c0_respcyc !== 1'b1 || c0_resp !== 64'hB2) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: rack=%b c0cyc=%b resp=%h want 0 1 b2",
                     s, m_bus_respack, c0_respcyc, c0_resp);
          end
          tick();
        end
      end
      c0_respack = 1;
      #1;
      n_checks++;
      if (c0_respcyc !== 1'b1 || m_bus_respack !== 1'b1 || owner !== 2'b10) begin
        n_fail++;
        $display("FAIL stall_beat[%0d]: c0cyc=%b rack=%b own=%b want 1 1 10",
                 i, c0_respcyc, m_bus_respack, owner);
      end
      tick();
    end
    clear_inputs();
    #1;
    n_checks++;
    if (owner[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end_idle: owner=%b want busy=0", owner);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    c0_reqcyc = 1; c0_req = 64'h1200; c0_reqtag = 13'h0000;
    tick();
    m_bus_reqack = 1;
    tick();
    m_bus_reqack = 0; c0_reqcyc = 0; c0_respack = 1;
    for (int i = 0; i < 4; i++) begin
      m_bus_respcyc = 1; m_bus_resp = 64'hC0 + 64'(i);
      tick();
    end
    m_bus_resp = 64'hC4; c1_reqcyc = 1;
    reset = 0;
    #1;
    n_checks++;
    if ({c0_respcyc, c1_respcyc, m_bus_respack, m_bus_reqcyc} !== 4'b0 || c0_resp !== '0 || owner !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_outputs: ctrl=%b resp=%h owner=%b want 0000 0 00",
               {c0_respcyc, c1_respcyc, m_bus_respack, m_bus_reqcyc}, c0_resp, owner);
    end
    tick();
    clear_inputs();
    c0_reqcyc = 1; c1_reqcyc = 1;
    reset = 1;
    tick();
    n_checks++;
    if (owner !== 2'b10) begin
      n_fail++;
      $display("FAIL midreset_first_tie: owner=%b want 10", owner);
    end
    clear_inputs();
    reset = 0;
    tick();
    reset = 1;
    tick();
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    test_reset();
    test_tie_alternate();
    test_read_p0();
    test_write_p1();
    test_resp_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
